// File: rtl/mem_bus_arbiter_if.sv
// Shared single-port memory bus between the arbiter (master) and the
// memory subsystem (slave).
interface mem_bus_arbiter_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_err_o;

  modport master (
    output bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o,
    input  bus_rdata_i, bus_ack_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, bus_err_o,
    output bus_rdata_i, bus_ack_i
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and the
// MEM stage. Data has priority; a fetch that has waited through
// STARVE_LIMIT data grants is forced through. Completed results are kept in
// one-entry buffers while the owning stage is held, and a watchdog aborts
// transactions the bus never acknowledges.
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  // instruction fetch side
  input  logic                if_ce_i,
  input  logic [31:0]         if_addr_i,
  input  logic                if_stall_i,
  output logic [31:0]         if_data_o,
  output logic                stallreq_if_o,
  // data access side
  input  logic                mem_ce_i,
  input  logic                mem_we_i,
  input  logic [3:0]          mem_sel_i,
  input  logic [31:0]         mem_addr_i,
  input  logic [31:0]         mem_wdata_i,
  input  logic                mem_stall_i,
  output logic [31:0]         mem_rdata_o,
  output logic                stallreq_mem_o,
  // shared memory bus
  mem_bus_arbiter_if.master   bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_INST, S_DATA} state_t;

  state_t           r_state;
  state_t           w_state_next;

  // registered bus fields, stable for the whole transaction
  logic             r_bus_req,   w_bus_req_next;
  logic             r_bus_we,    w_bus_we_next;
  logic [3:0]       r_bus_sel,   w_bus_sel_next;
  logic [31:0]      r_bus_addr,  w_bus_addr_next;
  logic [31:0]      r_bus_wdata, w_bus_wdata_next;

  logic [SW-1:0]    r_starve_cnt;
  logic [TW-1:0]    r_tmo_cnt;

  // result buffers
  logic             r_ibuf_valid;
  logic [31:0]      r_ibuf_addr;
  logic [31:0]      r_ibuf_data;
  logic             r_dbuf_valid;
  logic [31:0]      r_dbuf_data;

  logic             w_ihit;
  logic             w_inst_pend;
  logic             w_data_pend;
  logic             w_busy;
  logic             w_timeout;
  logic             w_done;
  logic             w_inst_done;
  logic             w_data_done;
  logic [31:0]      w_rdata;
  logic             w_starved;
  logic             w_grant_data;
  logic             w_grant_inst;
  logic             w_write_hit;

  assign w_ihit       = r_ibuf_valid & (r_ibuf_addr == if_addr_i);
  assign w_inst_pend  = if_ce_i & ~w_ihit;
  assign w_data_pend  = mem_ce_i & ~r_dbuf_valid;
  assign w_busy       = (r_state != S_IDLE);
  // an ack in the very cycle the watchdog expires wins over the abort
  assign w_timeout    = w_busy & ~bus.bus_ack_i & (r_tmo_cnt == TMO_MAX);
  assign w_done       = w_busy & (bus.bus_ack_i | w_timeout);
  assign w_rdata      = w_timeout ? 32'h0 : bus.bus_rdata_i;
  assign w_inst_done  = (r_state == S_INST) & w_done;
  assign w_data_done  = (r_state == S_DATA) & w_done;
  assign w_starved    = (r_starve_cnt >= STARVE_MAX);
  assign w_grant_data = (r_state == S_IDLE) & w_data_pend & (~w_inst_pend | ~w_starved);
  assign w_grant_inst = (r_state == S_IDLE) & ~w_grant_data & w_inst_pend;
  // a completed store to the buffered fetch word makes that word stale
  assign w_write_hit  = w_data_done & r_bus_we & (r_bus_addr[31:2] == r_ibuf_addr[31:2]);

  assign if_data_o      = ~if_ce_i  ? 32'h0 : (w_inst_done ? w_rdata : r_ibuf_data);
  assign mem_rdata_o    = ~mem_ce_i ? 32'h0 : (w_data_done ? w_rdata : r_dbuf_data);
  assign stallreq_if_o  = w_inst_pend & ~w_inst_done;
  assign stallreq_mem_o = w_data_pend & ~w_data_done;

  assign bus.bus_req_o   = r_bus_req;
  assign bus.bus_we_o    = r_bus_we;
  assign bus.bus_sel_o   = r_bus_sel;
  assign bus.bus_addr_o  = r_bus_addr;
  assign bus.bus_wdata_o = r_bus_wdata;
  assign bus.bus_err_o   = w_timeout;

  // Next state and next bus fields: latch on grant, clear on completion
  always_comb begin
    w_state_next     = r_state;
    w_bus_req_next   = r_bus_req;
    w_bus_we_next    = r_bus_we;
    w_bus_sel_next   = r_bus_sel;
    w_bus_addr_next  = r_bus_addr;
    w_bus_wdata_next = r_bus_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_grant_data) begin
          w_state_next     = S_DATA;
          w_bus_req_next   = 1'b1;
          w_bus_we_next    = mem_we_i;
          w_bus_sel_next   = mem_sel_i;
          w_bus_addr_next  = mem_addr_i;
          w_bus_wdata_next = mem_wdata_i;
        end else if (w_grant_inst) begin
          w_state_next     = S_INST;
          w_bus_req_next   = 1'b1;
          w_bus_we_next    = 1'b0;
          w_bus_sel_next   = 4'b1111;
          w_bus_addr_next  = if_addr_i;
          w_bus_wdata_next = 32'h0;
        end
      end
      S_INST, S_DATA: begin
        if (w_done) begin
          w_state_next     = S_IDLE;
          w_bus_req_next   = 1'b0;
          w_bus_we_next    = 1'b0;
          w_bus_sel_next   = 4'b0000;
          w_bus_addr_next  = 32'h0;
          w_bus_wdata_next = 32'h0;
        end
      end
      default: begin
        w_state_next     = S_IDLE;
        w_bus_req_next   = 1'b0;
        w_bus_we_next    = 1'b0;
        w_bus_sel_next   = 4'b0000;
        w_bus_addr_next  = 32'h0;
        w_bus_wdata_next = 32'h0;
      end
    endcase
  end

  // State register and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_sel   <= 4'b0000;
      r_bus_addr  <= 32'h0;
      r_bus_wdata <= 32'h0;
    end else begin
      r_state     <= w_state_next;
      r_bus_req   <= w_bus_req_next;
      r_bus_we    <= w_bus_we_next;
      r_bus_sel   <= w_bus_sel_next;
      r_bus_addr  <= w_bus_addr_next;
      r_bus_wdata <= w_bus_wdata_next;
    end
  end

  // Count data grants that overtook a waiting fetch, saturating at the limit
  always_ff @(posedge clk) begin
    if (rst || !w_inst_pend || w_grant_inst) begin
      r_starve_cnt <= '0;
    end else if (w_grant_data && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + SW'(1);
    end
  end

  // Watchdog: counts cycles spent waiting for the current bus ack
  always_ff @(posedge clk) begin
    if (rst || !w_busy || w_done) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end

  // Fetch buffer: fill when IF is held at completion, drop on advance/flush/store hit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ibuf_valid <= 1'b0;
      r_ibuf_addr  <= 32'h0;
      r_ibuf_data  <= 32'h0;
    end else if (w_inst_done && if_ce_i && if_stall_i) begin
      r_ibuf_valid <= 1'b1;
      r_ibuf_addr  <= r_bus_addr;
      r_ibuf_data  <= w_rdata;
    end else if (r_ibuf_valid && (!if_stall_i || (if_addr_i != r_ibuf_addr) || w_write_hit)) begin
      r_ibuf_valid <= 1'b0;
    end
  end

  // Data buffer: fill when MEM is held at completion (stores too), drop on advance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dbuf_valid <= 1'b0;
      r_dbuf_data  <= 32'h0;
    end else if (w_data_done && mem_ce_i && mem_stall_i) begin
      r_dbuf_valid <= 1'b1;
      r_dbuf_data  <= w_rdata;
    end else if (r_dbuf_valid && !mem_stall_i) begin
      r_dbuf_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one single-port memory bus between instruction fetch (PC/IF) and data access (MEM stage), replacing the separate ROM and RAM ports.
- Fixed data-over-fetch priority with a fetch anti-starvation limit.
- Drives stall requests to ctrl while a requester waits.
- Holds completed results in one-entry buffers until the owning stage advances.
- Bus timeout watchdog.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is pending before the fetch is forced.
- TIMEOUT_CYCLES, 255: cycles without bus_ack_i before a transaction is aborted.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- if_ce_i  in  1  fetch request
- if_addr_i  in  32  fetch address
- if_stall_i  in  1  IF stage held this cycle (stall[1] from ctrl)
- if_data_o  out  32  fetched instruction
- stallreq_if_o  out  1  fetch stall request to ctrl
- mem_ce_i  in  1  data request
- mem_we_i  in  1  1 = write
- mem_sel_i  in  4  byte enables
- mem_addr_i  in  32  data address
- mem_wdata_i  in  32  store data
- mem_stall_i  in  1  MEM stage held this cycle (stall[4])
- mem_rdata_o  out  32  load data
- stallreq_mem_o  out  1  data stall request to ctrl
- bus_req_o  out  1  transaction active
- bus_we_o  out  1  bus write
- bus_sel_o  out  4  bus byte enables
- bus_addr_o  out  32  bus address
- bus_wdata_o  out  32  bus write data
- bus_rdata_i  in  32  bus read data
- bus_ack_i  in  1  one-cycle completion; sampled only while bus_req_o=1
- bus_err_o  out  1  one-cycle pulse on timeout

Behaviour:
- Reset:
  - FSM IDLE; all bus_* outputs 0; bus_err_o 0.
  - Buffers invalid; starve_cnt and timeout counter 0.
  - Outputs follow the combinational equations below, so data outputs read 0.
- Reset mid-transaction: bus_req_o is 0 after the reset edge; a late bus_ack_i in IDLE is ignored.
- Buffers:
  - ibuf holds {valid, addr, data}; dbuf holds {valid, data}.
  - ihit = ibuf.valid & ibuf.addr==if_addr_i.
- Pending:
  - inst_pend = if_ce_i & ~ihit.
  - data_pend = mem_ce_i & ~dbuf.valid.
- FSM states: IDLE, INST, DATA.
  - IDLE → DATA if data_pend & (~inst_pend | starve_cnt<STARVE_LIMIT).
  - Otherwise IDLE → INST if inst_pend.
  - The grant edge registers bus_req_o=1 and latches addr/we/sel/wdata. For INST: we=0, sel=4'b1111.
  - INST/DATA: bus fields held stable until ack or timeout; then → IDLE and bus_req_o=0 at the next edge.
  - Minimum one IDLE cycle between transactions.
- starve_cnt:
  - +1 on each DATA grant while inst_pend.
  - Cleared on INST grant or whenever ~inst_pend; saturates at STARVE_LIMIT.
- Completion cycle: (state==INST|DATA) & bus_ack_i, or timeout.
- Data outputs:
  - if_data_o = 0 if ~if_ce_i; else bus_rdata_i on INST completion; else ibuf.data.
  - mem_rdata_o = 0 if ~mem_ce_i; else bus_rdata_i on DATA completion; else dbuf.data.
- Stall outputs:
  - stallreq_if_o = inst_pend & ~(INST completion).
  - stallreq_mem_o = data_pend & ~(DATA completion).
  - Both are combinational.
- Buffer fill at completion:
  - Written only if the matching ce_i is still 1 and the matching stall_i=1 (stage did not advance).
  - valid<=1, data<=rdata; ibuf.addr<=latched bus addr.
  - Completed writes also set dbuf.valid (data ignored) so a held store is not reissued.
- Buffer clear:
  - Valid buffer cleared at any edge where its stall_i=0.
  - ibuf also cleared when if_addr_i≠ibuf.addr (flush/branch).
  - ibuf cleared when a data write completes to the same word (addr[31:2] equal).
- Requester drop: if ce_i drops mid-transaction, the transaction still completes and its result is discarded.
- Timeout:
  - Counter runs in INST/DATA and resets in IDLE.
  - Reaching TIMEOUT_CYCLES: completion with rdata forced to 0x00000000, bus_err_o=1 for one cycle.
- Simultaneous first requests: data wins unless starve_cnt==STARVE_LIMIT.

Test Plan:
- Fetch alone, if_addr_i=0x00000100, ack 2 cycles after bus_req_o with rdata 0x3C010101 → stallreq_if_o high 2 cycles, if_data_o=0x3C010101 in the ack cycle, bus_req_o low next cycle.
- Fetch and load requested together, load addr 0x200 → DATA granted first (bus_addr_o=0x200, we=0); fetch issued after the DATA ack plus one IDLE cycle.
- Load completes while mem_stall_i=1 for 3 more cycles, rdata 0xDEADBEEF → no reissue, mem_rdata_o=0xDEADBEEF held, dbuf cleared when mem_stall_i falls.
- Back-to-back data requests with fetch pending, STARVE_LIMIT=4 → 4 DATA grants, then an INST grant even though data is pending.
- No ack for 255 cycles → bus_err_o pulses once, if_data_o=0 that cycle, FSM returns to IDLE.
- Assert rst mid-DATA, then ack next cycle → bus_req_o 0 after the reset edge, ack ignored, buffers invalid.
